// File: rtl/counter_display_pkg.sv
// rtl/counter_display_pkg.sv - shared types and constants for the counter display driver
// Contents:
//   conv_state_t : converter FSM states (IDLE, SHIFT, LATCH)
//   SEG_0..SEG_9 : active-high {g,f,e,d,c,b,a} digit patterns
//   SEG_BLANK    : all segments off (active-high)
//   NUM_DIGITS   : number of multiplexed digits
//   bcd_adjust   : add-3 correction applied to every BCD nibble >= 5
package counter_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            res[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_display_driver_seg7_decode.sv
// rtl/counter_display_driver_seg7_decode.sv - combinational BCD nibble to 7-segment pattern
// Ports:
//   nibble  in  4  BCD digit
//   pattern out 7  active-high {g,f,e,d,c,b,a}; nibbles above 9 decode to blank
module seg7_decode
    import counter_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/counter_display_driver.sv
// rtl/counter_display_driver.sv - binary to BCD converter with multiplexed 7-segment scan
// Ports:
//   clk    in   1  system clock
//   clear  in   1  synchronous active-low reset
//   value  in   8  unsigned binary value to display
//   seg    out  7  segment lines {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an     out  3  active-low one-hot digit enables, an[0] = units
//   digits out 12  latched BCD {hundreds,tens,units}
//   ready  out  1  converter idle
// Parameters: REFRESH_DIV (cycles per digit, >= 2), SEG_ACTIVE_LOW
// Optional macro: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits
module counter_display_driver
    import counter_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] digits,
    output logic        ready
);

    localparam int             RW           = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0]  REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_RESET    = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

    conv_state_t state, state_next;
    logic [7:0]  sh;
    logic [7:0]  cap;
    logic [7:0]  last_val;
    logic [11:0] bcd;
    logic [2:0]  bit_cnt;
    logic        pend;
    logic        start;

    // pend guarantees one conversion after reset even when value equals last_val.
    assign start = pend || (value != last_val);
    assign ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!clear) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == 3'd7) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            sh       <= '0;
            cap      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            pend     <= 1'b1;
            last_val <= '0;
            digits   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh      <= value;
                        cap     <= value;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        pend    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Adjusted MSB is always 0 for 8-bit inputs (max 255), so dropping it is safe.
                    {bcd, sh} <= {bcd_adjust(bcd)[10:0], sh, 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                ST_LATCH: begin
                    digits   <= bcd;
                    last_val <= cap;
                end
                default: ;
            endcase
        end
    end

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    sel;

    always_ff @(posedge clk) begin
        if (!clear) begin
            refresh_cnt <= '0;
            sel         <= 2'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            sel         <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    logic [3:0] nibble;
    logic [6:0] pattern;
    logic [6:0] pattern_shown;
    logic       blank;

    always_comb begin
        nibble = digits[3:0];
        case (sel)
            2'd1:    nibble = digits[7:4];
            2'd2:    nibble = digits[11:8];
            default: nibble = digits[3:0];
        endcase
    end

    seg7_decode u_decode (
        .nibble  (nibble),
        .pattern (pattern)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = ((sel == 2'd2) && (digits[11:8] == 4'd0)) ||
                   ((sel == 2'd1) && (digits[11:4] == 8'd0));
`else
    assign blank = 1'b0;
`endif

    assign pattern_shown = blank ? SEG_BLANK : pattern;

    // an and seg are both registered from the same sel so they switch together.
    always_ff @(posedge clk) begin
        if (!clear) begin
            an  <= 3'b110;
            seg <= SEG_RESET;
        end else begin
            an  <= ~(3'b001 << sel);
            seg <= SEG_ACTIVE_LOW ? ~pattern_shown : pattern_shown;
        end
    end

endmodule
